// File: rtl/cachepkg.sv
// Shared types for the cache-to-memory arbiter.
// No logic; enums and a small helper only.
// No flow control here.
package cachepkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_INSTR,
    REQ_DATA
  } requester_t;

  function automatic requester_t other_side(input requester_t r);
    return (r == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin choice between the instruction and data requesters.
// Latency: combinational, zero cycles.
// Backpressure: none; grant is meaningful only when a request is present.
module rr_picker
  import cachepkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  requester_t last,
  output requester_t grant
);

  always_comb begin
    grant = REQ_DATA;
    if (i_req && d_req) begin
      // Contention goes to whoever was not served last.
      grant = other_side(last);
    end else if (i_req) begin
      grant = REQ_INSTR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto one backing memory; ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: request-sampled cycle, ISSUE, RESP -> ack three cycles after req at best.
// Backpressure: one transaction in flight; requesters hold req and command until their ack.
module mem_arbiter
  import cachepkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int ADDRESSWIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [ADDRESSWIDTH-1:0] i_addr,
  input  logic [DATAWIDTH-1:0]    i_wdata,
  output logic                    i_ack,
  output logic [DATAWIDTH-1:0]    i_rdata,
  output logic                    i_err,

  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESSWIDTH-1:0] d_addr,
  input  logic [DATAWIDTH-1:0]    d_wdata,
  output logic                    d_ack,
  output logic [DATAWIDTH-1:0]    d_rdata,
  output logic                    d_err,

  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_wdata,
  input  logic                    mem_ready,
  input  logic [DATAWIDTH-1:0]    mem_rdata
);

  arb_state_t state, state_n;
  // last_grant is both the round-robin pointer and the owner of the
  // transaction in flight: it only changes on entry to ISSUE.
  requester_t last_grant;
  requester_t grant;

  logic                    any_req;
  logic                    timeout_hit;
  logic                    win_we;
  logic [ADDRESSWIDTH-1:0] win_addr;
  logic [DATAWIDTH-1:0]    win_wdata;
  logic                    mem_req_n;
  logic                    i_ack_n;
  logic                    d_ack_n;
  logic                    enter_resp;

  rr_picker u_picker (
    .i_req (i_req),
    .d_req (d_req),
    .last  (last_grant),
    .grant (grant)
  );

  assign any_req = i_req | d_req;

  always_comb begin
    win_we    = i_we;
    win_addr  = i_addr;
    win_wdata = i_wdata;
    if (grant == REQ_DATA) begin
      win_we    = d_we;
      win_addr  = d_addr;
      win_wdata = d_wdata;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // Fires on the last permitted WAIT cycle; mutually exclusive with mem_ready.
  assign timeout_hit = (state == WAIT) && !mem_ready &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == WAIT && state_n == WAIT) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_err <= 1'b0;
      d_err <= 1'b0;
    end else begin
      i_err <= timeout_hit && (last_grant == REQ_INSTR);
      d_err <= timeout_hit && (last_grant == REQ_DATA);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign i_err       = 1'b0;
  assign d_err       = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   state_n = mem_ready ? RESP : WAIT;
      WAIT:    if (mem_ready || timeout_hit) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    mem_req_n  = (state_n == ISSUE) || (state_n == WAIT);
    enter_resp = (state != RESP) && (state_n == RESP);
    i_ack_n    = (state_n == RESP) && (last_grant == REQ_INSTR);
    d_ack_n    = (state_n == RESP) && (last_grant == REQ_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ_INSTR;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      mem_req <= mem_req_n;
      i_ack   <= i_ack_n;
      d_ack   <= d_ack_n;

      if (state == IDLE && any_req) begin
        last_grant <= grant;
        mem_we     <= win_we;
        mem_addr   <= win_addr;
        mem_wdata  <= win_wdata;
      end

      if (enter_resp) begin
        if (last_grant == REQ_INSTR) begin
          i_rdata <= timeout_hit ? '0 : mem_rdata;
        end else begin
          d_rdata <= timeout_hit ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;
  import cachepkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0, i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic          i_ack, i_err;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata;

  always #5 clock = ~clock;

  mem_arbiter #(
    .DATAWIDTH      (DW),
    .ADDRESSWIDTH   (AW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory answers mem_lat cycles after it first sees mem_req (0 = in ISSUE).
  int mem_lat = 0;
  int mem_cnt = 0;
  always @(negedge clock) begin
    if (mem_req === 1'b1) begin
      mem_ready = (mem_cnt == mem_lat);
      mem_cnt++;
    end else begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end
  end
  assign mem_rdata = (mem_addr == 32'h100) ? 32'hDEADBEEF : ~mem_addr;

  // Acks must be exclusive and one cycle wide, in every test.
  logic prev_i = 1'b0, prev_d = 1'b0;
  always @(negedge clock) begin
    if (i_ack === 1'b1 || d_ack === 1'b1) begin
      check_eq("ack_excl", 32'(i_ack & d_ack), 32'd0);
      check_eq("ack_pulse", 32'((i_ack & prev_i) | (d_ack & prev_d)), 32'd0);
    end
    prev_i = (i_ack === 1'b1);
    prev_d = (d_ack === 1'b1);
  end

  // Waits for an ack; who: 0 instr, 1 data, -1 none within budget.
  task automatic wait_ack(input int budget, output int who, output int cycles,
                          output logic [31:0] rdata, output logic err,
                          output logic [31:0] c_addr, output logic [31:0] c_wdata,
                          output logic c_we, output int unstable, output logic mr_at_ack);
    logic seen;
    who = -1; cycles = 0; rdata = '0; err = 1'b0; c_addr = '0; c_wdata = '0;
    c_we = 1'b0; unstable = 0; mr_at_ack = 1'b0; seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      cycles++;
      if (mem_req === 1'b1) begin
        if (!seen) begin
          c_addr = mem_addr; c_wdata = mem_wdata; c_we = mem_we; seen = 1'b1;
        end else if (mem_addr !== c_addr || mem_wdata !== c_wdata || mem_we !== c_we) begin
          unstable++;
        end
      end
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        who       = (d_ack === 1'b1) ? 1 : 0;
        rdata     = (d_ack === 1'b1) ? d_rdata : i_rdata;
        err       = (d_ack === 1'b1) ? d_err : i_err;
        mr_at_ack = mem_req;
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  int          who, cyc, unst;
  logic [31:0] rd, ca, cw;
  logic        er, cwe, mra;

  initial begin : main
    // Reset state
    do_reset();
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    check_eq("rst_errs", 32'({i_err, d_err}), 32'd0);
    check_eq("rst_i_rdata", i_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_state", 32'(dut.state), 32'(IDLE));
    check_eq("rst_last", 32'(dut.last_grant), 32'(REQ_INSTR));

    // Simultaneous pair from reset: data first; data re-requests at once,
    // so the second pair goes to instruction.
    mem_lat = 1;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300;
    wait_ack(20, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("pair1_who", who, 32'd1);
    check_eq("pair1_rdata", rd, ~32'h300);
    d_addr = 32'h304;
    wait_ack(20, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("pair2_who", who, 32'd0);
    check_eq("pair2_rdata", rd, ~32'h200);
    i_req = 1'b0;
    wait_ack(20, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("pair3_who", who, 32'd1);
    check_eq("pair3_rdata", rd, ~32'h304);
    d_req = 1'b0;
    repeat (2) @(negedge clock);

    // Data read, memory answers two cycles after mem_req
    mem_lat = 2;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    wait_ack(20, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("rd_who", who, 32'd1);
    check_eq("rd_latency", cyc, 32'd4);
    check_eq("rd_rdata", rd, 32'hDEADBEEF);
    check_eq("rd_cmd_addr", ca, 32'h100);
    check_eq("rd_cmd_we", 32'(cwe), 32'd0);
    check_eq("rd_stable", unst, 32'd0);
    d_req = 1'b0;
    @(negedge clock);
    check_eq("rd_ack_drop", 32'({i_ack, d_ack}), 32'd0);
    @(negedge clock);

    // Data write accepted in ISSUE: ack in the third cycle counting the req cycle
    mem_lat = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h0BEEFA55;
    wait_ack(20, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("wr_who", who, 32'd1);
    check_eq("wr_latency", cyc, 32'd2);
    check_eq("wr_cmd_we", 32'(cwe), 32'd1);
    check_eq("wr_cmd_addr", ca, 32'h40);
    check_eq("wr_cmd_wdata", cw, 32'h0BEEFA55);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clock);

    // Reset while waiting on memory
    mem_lat = 1000;
    d_req = 1'b1; d_addr = 32'h500;
    repeat (3) @(negedge clock);
    check_eq("rw_pre_state", 32'(dut.state), 32'(WAIT));
    check_eq("rw_pre_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rw_mem_req", 32'(mem_req), 32'd0);
    check_eq("rw_state", 32'(dut.state), 32'(IDLE));
    check_eq("rw_acks", 32'({i_ack, d_ack}), 32'd0);
    reset = 1'b0; d_req = 1'b0; mem_lat = 0;
    wait_ack(6, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("rw_no_ack", who, 32'hFFFF_FFFF);

    // Memory never answers (watchdog) / answers late (no watchdog)
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h80;
`ifdef ARB_TIMEOUT_EN
    mem_lat = 1000;
    wait_ack(30, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("to_who", who, 32'd0);
    check_eq("to_latency", cyc, 32'd6);
    check_eq("to_err", 32'(er), 32'd1);
    check_eq("to_rdata", rd, 32'd0);
    check_eq("to_mem_req", 32'(mra), 32'd0);
`else
    mem_lat = 20;
    wait_ack(40, who, cyc, rd, er, ca, cw, cwe, unst, mra);
    check_eq("slow_who", who, 32'd0);
    check_eq("slow_latency", cyc, 32'd22);
    check_eq("slow_err", 32'(er), 32'd0);
    check_eq("slow_rdata", rd, ~32'h80);
`endif
    i_req = 1'b0;
    repeat (2) @(negedge clock);

    // Ten back-to-back transactions with both sides always requesting
    do_reset();
    mem_lat = 1;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_addr = 32'h2000;
    for (int n = 0; n < 10; n++) begin
      wait_ack(20, who, cyc, rd, er, ca, cw, cwe, unst, mra);
      check_eq($sformatf("alt_who_%0d", n), who, (n % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("alt_rdata_%0d", n), rd, (n % 2 == 0) ? ~32'h2000 : ~32'h1000);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL sim_timeout: got no completion, expected finish before 200000ns");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, width of all data buses.
REQ-002 SHALL have parameter ADDRESSWIDTH, default 32, width of all address buses.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit when ARB_TIMEOUT_EN is defined.
REQ-004 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_req, i_we  input  1 each  instruction-cache miss/writeback request and write enable.
REQ-007 SHALL have ports i_addr  input  ADDRESSWIDTH, and i_wdata  input  DATAWIDTH.
REQ-008 SHALL have ports i_ack  output  1, i_rdata  output  DATAWIDTH, and i_err  output  1  completion to the instruction cache.
REQ-009 SHALL have ports d_req, d_we, d_addr, d_wdata, d_ack, d_rdata and d_err, with the same directions and widths as the i_* ports, for the data cache.
REQ-010 SHALL have ports mem_req, mem_we  output  1; mem_addr  output  ADDRESSWIDTH; mem_wdata  output  DATAWIDTH  backing-memory command.
REQ-011 SHALL have ports mem_ready  input  1, and mem_rdata  input  DATAWIDTH  backing-memory completion.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-013 SHALL, in IDLE, remain in IDLE when no request is pending.
REQ-014 SHALL, in IDLE with any request pending, select a winner, latch its we/addr/wdata and id, and go to ISSUE next cycle.
REQ-015 SHALL arbitrate round-robin: when i_req and d_req are both high, the requester not granted last wins; after reset the data side has priority.
REQ-016 SHALL drive mem_req=1 with the latched command in ISSUE and WAIT only, and hold mem_we/mem_addr/mem_wdata stable while mem_req=1.
REQ-017 SHALL go from ISSUE to WAIT.
REQ-018 SHALL, in WAIT, capture mem_rdata into the response register on mem_ready=1 and go to RESP; mem_ready in ISSUE SHALL also be accepted and go straight to RESP.
REQ-019 SHALL, in RESP, pulse the winner's ack for exactly one cycle with rdata valid that cycle (rdata is don't-care for writes), then return to IDLE.
REQ-020 SHALL give a minimum request-to-ack latency of 3 cycles (request sampled, ISSUE, mem_ready in ISSUE, RESP).
REQ-021 SHALL ignore a requester's req while its own transaction is in progress; a requester SHALL hold req and its command until it sees ack.
REQ-022 SHALL never assert both i_ack and d_ack in the same cycle.
REQ-023 SHALL update the last-granted pointer only on entry to ISSUE.
REQ-024 SHALL register all outputs.

Reset
REQ-025 SHALL, on reset=1 at posedge, enter IDLE, set the last-granted pointer to instruction, and clear mem_req, mem_we, mem_addr, mem_wdata, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata and the watchdog counter, all to 0.
REQ-026 SHALL abandon an in-flight transaction on reset mid-operation without issuing an ack; mem_req SHALL be 0 the cycle after reset.

Configuration
REQ-027 SHALL, with ARB_TIMEOUT_EN defined, count WAIT cycles and, when the count reaches TIMEOUT_CYCLES without mem_ready, go to RESP with the winner's err and ack both high, rdata=0, and mem_req dropped.
REQ-028 SHALL, without ARB_TIMEOUT_EN, have no counter, hold WAIT indefinitely, and tie i_err/d_err to 0.

Structure
REQ-029 SHALL take from cachepkg the typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP} and the typedef enum requester_t {REQ_INSTR, REQ_DATA}.
REQ-030 SHALL place the winner selection in the combinational sub-module rr_picker (inputs i_req, d_req, last; output grant as requester_t).

Verification
REQ-031 SHALL cover: single data read to addr 0x100, mem_ready 2 cycles after mem_req, mem_rdata 0xDEADBEEF -> one d_ack pulse with d_rdata=0xDEADBEEF, i_ack stays 0.
REQ-032 SHALL cover: i_req and d_req both high from reset -> data served first, then instruction; next simultaneous pair -> instruction served first.
REQ-033 SHALL cover: data write addr 0x40 wdata 0x0BEEFA55 with mem_ready in ISSUE -> mem_we=1, mem_wdata=0x0BEEFA55, d_ack exactly 3 cycles after d_req.
REQ-034 SHALL cover: reset asserted during WAIT -> no ack, mem_req=0 next cycle, FSM in IDLE.
REQ-035 SHALL cover: ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ready held 0 -> after 4 WAIT cycles i_ack=1, i_err=1, i_rdata=0, mem_req=0.
REQ-036 SHALL cover: continuous i_req and d_req for 10 transactions -> grants strictly alternate and acks never overlap.
